// File: rtl/vga_rect_plot_engine.sv
// Pixel-plot engine: turns one point/fill/clear/outline command into a
// clipped raster-order pixel stream with valid/ready backpressure.
module vga_rect_plot_engine #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [X_W-1:0]      cmd_x0,
    input  logic [Y_W-1:0]      cmd_y0,
    input  logic [X_W-1:0]      cmd_x1,
    input  logic [Y_W-1:0]      cmd_y1,
    input  logic [COLOUR_W-1:0] cmd_colour,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [X_W-1:0]      pix_x,
    output logic [Y_W-1:0]      pix_y,
    output logic [COLOUR_W-1:0] pix_colour,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [1:0] M_POINT   = 2'b00;
    localparam logic [1:0] M_CLEAR   = 2'b10;
    localparam logic [1:0] M_OUTLINE = 2'b11;

    localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

    state_t state, state_nx;

    logic [X_W-1:0]      xmin, xmax, a_xmin, a_xmax;
    logic [Y_W-1:0]      ymin, ymax, a_ymin, a_ymax;
    logic [X_W:0]        cx;
    logic [Y_W:0]        cy;
    logic [COLOUR_W-1:0] colour;
    logic [1:0]          mode;

    logic accept, on_screen, on_edge, emit, advance, last, row_end;

    assign accept    = (state == IDLE) && cmd_valid;
    // Cursor is one bit wider than the bounds so xmax at full range compares cleanly.
    assign on_screen = (cx < X_LIM) && (cy < Y_LIM);
    assign on_edge   = (mode != M_OUTLINE)
                    || (cx == {1'b0, xmin}) || (cx == {1'b0, xmax})
                    || (cy == {1'b0, ymin}) || (cy == {1'b0, ymax});
    assign emit      = on_screen && on_edge;
    assign row_end   = (cx == {1'b0, xmax});
    assign last      = row_end && (cy == {1'b0, ymax});
    assign advance   = (state == DRAW) && (!emit || pix_ready);

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign pix_valid  = (state == DRAW) && emit;
    assign pix_x      = cx[X_W-1:0];
    assign pix_y      = cy[Y_W-1:0];
    assign pix_colour = colour;

    always_comb begin
        a_xmin = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
        a_xmax = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
        a_ymin = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
        a_ymax = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
        case (cmd_mode)
            M_POINT: begin
                a_xmin = cmd_x0;
                a_xmax = cmd_x0;
                a_ymin = cmd_y0;
                a_ymax = cmd_y0;
            end
            M_CLEAR: begin
                a_xmin = '0;
                a_xmax = X_W'(SCREEN_W - 1);
                a_ymin = '0;
                a_ymax = Y_W'(SCREEN_H - 1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = DRAW;
            DRAW:    if (advance && last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xmin   <= '0;
            xmax   <= '0;
            ymin   <= '0;
            ymax   <= '0;
            cx     <= '0;
            cy     <= '0;
            colour <= '0;
            mode   <= '0;
        end else if (accept) begin
            xmin   <= a_xmin;
            xmax   <= a_xmax;
            ymin   <= a_ymin;
            ymax   <= a_ymax;
            cx     <= {1'b0, a_xmin};
            cy     <= {1'b0, a_ymin};
            colour <= cmd_colour;
            mode   <= cmd_mode;
        end else if (advance && !last) begin
            if (row_end) begin
                cx <= {1'b0, xmin};
                cy <= cy + (Y_W+1)'(1);
            end else begin
                cx <= cx + (X_W+1)'(1);
            end
        end
    end

endmodule
